i2s_clk_ctrl: RTL and testbench

I2S_CLK_CTRL -- requirements
Module: i2s_clk_ctrl

---
 rtl/i2s_pkg.sv | 40 ++++
 rtl/i2s_frame_cnt.sv | 75 +++++++
 rtl/i2s_clk_ctrl.sv | 154 +++++++++++++++
 tb/tb_i2s_clk_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared state encoding, output bundle and frame arithmetic for the I2S clocks.
// ST_WARMUP exists only when I2S_WARMUP_EN is defined.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STOP   = 2'd2
`ifdef I2S_WARMUP_EN
        ,
        ST_WARMUP = 2'd3
`endif
    } state_e;

    typedef struct packed {
        logic busy;
        logic mclk;
        logic sclk;
        logic lrck;
        logic sclk_rise;
        logic sclk_fall;
        logic frame_start;
    } clk_out_t;

    function automatic int unsigned frame_len(
        input int unsigned mclk_div,
        input int unsigned sclk_ratio,
        input int unsigned slot_bits
    );
        return mclk_div * sclk_ratio * 2 * slot_bits;
    endfunction

    function automatic int unsigned bit_period(
        input int unsigned mclk_div,
        input int unsigned sclk_ratio
    );
        return mclk_div * sclk_ratio;
    endfunction

endpackage

// File: rtl/i2s_frame_cnt.sv
// Frame position counter plus, with I2S_WARMUP_EN, the warm-up frame counter.
// clear has priority over advance; wrap_o flags the last cycle of a frame.
module i2s_frame_cnt #(
    parameter int unsigned F             = 64
`ifdef I2S_WARMUP_EN
    ,
    parameter int unsigned WARMUP_FRAMES = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 advance_i,
    output logic [$clog2(F)-1:0] cnt_o,
`ifdef I2S_WARMUP_EN
    output logic                 warm_done_o,
`endif
    output logic                 wrap_o
);

    localparam int unsigned CW = $clog2(F);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o = (cnt_q == CW'(F - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef I2S_WARMUP_EN
    localparam int unsigned WW = $clog2(WARMUP_FRAMES + 1);

    logic [WW-1:0] wfrm_q;
    logic [WW-1:0] wfrm_d;
    logic          wlast;

    assign wlast       = (wfrm_q == WW'(WARMUP_FRAMES - 1));
    assign warm_done_o = wrap_o && wlast;

    // Saturates on the last frame so it never wraps while RUN keeps counting.
    always_comb begin
        wfrm_d = wfrm_q;
        if (clear_i) begin
            wfrm_d = '0;
        end else if (advance_i && wrap_o && !wlast) begin
            wfrm_d = wfrm_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wfrm_q <= '0;
        end else begin
            wfrm_q <= wfrm_d;
        end
    end
`endif

endmodule

// File: rtl/i2s_clk_ctrl.sv
// I2S master clock generator: mclk, sclk, lrck, edge strobes and bit index.
// Define I2S_WARMUP_EN to run mclk alone for WARMUP_FRAMES frames first.
module i2s_clk_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned MCLK_DIV      = 4,
    parameter int unsigned SCLK_RATIO    = 8,
    parameter int unsigned SLOT_BITS     = 32,
    parameter int unsigned WARMUP_FRAMES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         busy,
    output logic                         mclk,
    output logic                         sclk,
    output logic                         lrck,
    output logic                         sclk_rise,
    output logic                         sclk_fall,
    output logic                         frame_start,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx
);

    localparam int unsigned F  = frame_len(MCLK_DIV, SCLK_RATIO, SLOT_BITS);
    localparam int unsigned P  = bit_period(MCLK_DIV, SCLK_RATIO);
    localparam int unsigned CW = $clog2(F);
    localparam int unsigned BW = $clog2(SLOT_BITS);

    // An illegal parameter set keeps the block parked in IDLE.
    localparam bit CFG_OK = (MCLK_DIV >= 2) && (MCLK_DIV % 2 == 0)
                         && (SCLK_RATIO >= 2) && (SCLK_RATIO % 2 == 0)
                         && (SLOT_BITS >= 2) && (WARMUP_FRAMES >= 1);

    state_e        state_q;
    state_e        state_d;
    clk_out_t      out_q;
    clk_out_t      out_d;
    logic [BW-1:0] bidx_q;
    logic [BW-1:0] bidx_d;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_la;
    logic          wrap;
    logic          clear;
`ifdef I2S_WARMUP_EN
    logic          warm_done;
`endif

    i2s_frame_cnt #(
        .F             (F)
`ifdef I2S_WARMUP_EN
        ,
        .WARMUP_FRAMES (WARMUP_FRAMES)
`endif
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .advance_i   (!clear),
        .cnt_o       (cnt),
`ifdef I2S_WARMUP_EN
        .warm_done_o (warm_done),
`endif
        .wrap_o      (wrap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && CFG_OK) begin
`ifdef I2S_WARMUP_EN
                    state_d = ST_WARMUP;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef I2S_WARMUP_EN
            ST_WARMUP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (warm_done) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear = (state_q == ST_IDLE) || (state_d == ST_IDLE);

    // Outputs are decoded from the count the frame counter is about to hold,
    // so every flop shows the state and position of the same cycle.
    assign cnt_la = (clear || wrap) ? '0 : cnt + CW'(1);

    always_comb begin
        logic          on;
        logic          act;
        logic [CW-1:0] mod_m;
        logic [CW-1:0] mod_p;
        on     = (state_d != ST_IDLE);
        act    = (state_d == ST_RUN) || (state_d == ST_STOP);
        mod_m  = cnt_la % CW'(MCLK_DIV);
        mod_p  = cnt_la % CW'(P);
        out_d  = '0;
        bidx_d = '0;
        out_d.busy = on;
        out_d.mclk = on && (mod_m >= CW'(MCLK_DIV / 2));
        if (act) begin
            out_d.sclk        = (mod_p >= CW'(P / 2));
            out_d.lrck        = (cnt_la >= CW'(F / 2));
            out_d.sclk_rise   = (mod_p == CW'(P / 2));
            out_d.sclk_fall   = (mod_p == '0);
            out_d.frame_start = (cnt_la == '0);
            bidx_d = BW'((cnt_la / CW'(P)) % CW'(SLOT_BITS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            bidx_q  <= bidx_d;
        end
    end

    assign busy        = out_q.busy;
    assign mclk        = out_q.mclk;
    assign sclk        = out_q.sclk;
    assign lrck        = out_q.lrck;
    assign sclk_rise   = out_q.sclk_rise;
    assign sclk_fall   = out_q.sclk_fall;
    assign frame_start = out_q.frame_start;
    assign bit_idx     = bidx_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Directed and randomized bench for i2s_clk_ctrl against a frame-level model.
// Works with and without I2S_WARMUP_EN.
module tb_i2s_clk_ctrl;

    localparam int MD = 2;
    localparam int SR = 4;
    localparam int SB = 4;
    localparam int WF = 2;
    localparam int P  = MD * SR;
    localparam int F  = P * 2 * SB;
`ifdef I2S_WARMUP_EN
    localparam int WARM_CYC = WF * F;
`else
    localparam int WARM_CYC = 0;
`endif
    localparam int EXP_LAT = 1 + WARM_CYC;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_RUN  = 2;
    localparam int M_STOP = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic       busy;
    logic       mclk;
    logic       sclk;
    logic       lrck;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       frame_start;
    logic [1:0] bit_idx;
    logic [8:0] dut_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_wc   = 0;

    i2s_clk_ctrl #(
        .MCLK_DIV      (MD),
        .SCLK_RATIO    (SR),
        .SLOT_BITS     (SB),
        .WARMUP_FRAMES (WF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .busy        (busy),
        .mclk        (mclk),
        .sclk        (sclk),
        .lrck        (lrck),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .frame_start (frame_start),
        .bit_idx     (bit_idx)
    );

    assign dut_v = {busy, mclk, sclk, lrck, sclk_rise, sclk_fall,
                    frame_start, bit_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    // Frame-level view: a warm-up cycle count, then a position in the frame.
    function automatic void model_step(input logic e, input logic r);
        if (r) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_wc   = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (e) begin
                m_cnt  = 0;
                m_wc   = 0;
                m_mode = (WARM_CYC > 0) ? M_WARM : M_RUN;
            end
            M_WARM: begin
                if (!e) m_mode = M_IDLE;
                else if (m_wc == WARM_CYC - 1) begin
                    m_mode = M_RUN;
                    m_cnt  = 0;
                end else m_wc++;
            end
            M_RUN: begin
                if (!e) m_mode = M_STOP;
                m_cnt = (m_cnt + 1) % F;
            end
            default: begin
                if (e) begin
                    m_mode = M_RUN;
                    m_cnt  = (m_cnt + 1) % F;
                end else if (m_cnt == F - 1) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else m_cnt++;
            end
        endcase
    endfunction

    function automatic logic [8:0] exp_vec();
        bit on;
        bit act;
        int ph;
        logic [1:0] bi;
        on  = (m_mode != M_IDLE);
        act = (m_mode == M_RUN) || (m_mode == M_STOP);
        ph  = (m_mode == M_WARM) ? m_wc : m_cnt;
        bi  = act ? 2'((m_cnt / P) % SB) : 2'b00;
        return {on, on && ((ph % MD) >= MD / 2),
                act && ((m_cnt % P) >= P / 2),
                act && (m_cnt >= F / 2),
                act && ((m_cnt % P) == P / 2),
                act && ((m_cnt % P) == 0),
                act && (m_cnt == 0), bi};
    endfunction

    task automatic tick();
        logic en_s;
        logic rst_s;
        en_s  = en;
        rst_s = rst;
        @(posedge clk);
        model_step(en_s, rst_s);
        cyc++;
        #1;
        chk("model", 32'(dut_v), 32'(exp_vec()));
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (frame_start !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("fs_timeout", 32'(n < 400), 1);
    endtask

    task automatic wait_cnt(input int t);
        int n;
        n = 0;
        while (!((m_mode == M_RUN || m_mode == M_STOP) && m_cnt == t)
               && n < 200) begin
            tick();
            n++;
        end
        chk("cnt_timeout", 32'(n < 200), 1);
    endtask

    initial begin
        int n;
        int rises;
        int last_rise;
        int lr_rise;
        int fs_cyc;
        logic prev_lr;
        logic prev_sc;
        logic [1:0] bi_q[$];
        logic lr_q[$];

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        chk("rst_out", 32'(dut_v), 0);
        en = 1'b1;
        repeat (2) tick();
        chk("rst_prio", 32'(busy), 0);

        rst = 1'b0;
        tick();
        chk("busy_next", 32'(busy), 1);
        wait_fs(n);
        chk("start_lat", n, EXP_LAT - 1);

        prev_lr   = lrck;
        prev_sc   = sclk;
        rises     = 0;
        last_rise = -1;
        lr_rise   = -1;
        for (int i = 0; i < 2 * F; i++) begin
            if (sclk_fall) begin
                bi_q.push_back(bit_idx);
                lr_q.push_back(lrck);
            end
            if (sclk_rise) begin
                if (last_rise >= 0) chk("sclk_period", cyc - last_rise, P);
                last_rise = cyc;
                rises++;
            end
            if (lrck && !prev_lr) begin
                if (lr_rise >= 0) chk("lrck_period", cyc - lr_rise, F);
                lr_rise = cyc;
            end
            chk("rise_edge", 32'(sclk_rise), 32'(sclk && !prev_sc));
            prev_lr = lrck;
            prev_sc = sclk;
            tick();
        end
        chk("rise_count", rises, 2 * 8);
        chk("fall_count", bi_q.size(), 2 * 8);
        for (int i = 0; i < bi_q.size(); i++) begin
            chk("bit_idx_seq", 32'(bi_q[i]), i % 4);
            chk("lrck_seq", 32'(lr_q[i]), (i % 8) / 4);
        end

        wait_cnt(20);
        en = 1'b0;
        n  = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("stop_len", n, F - 20);
        chk("idle_out", 32'(dut_v), 0);

        en = 1'b1;
        tick();
        wait_fs(n);
        fs_cyc = cyc;
        wait_cnt(20);
        en = 1'b0;
        wait_cnt(40);
        en = 1'b1;
        tick();
        wait_fs(n);
        chk("no_gap", cyc - fs_cyc, F);

        wait_cnt(37);
        rst = 1'b1;
        tick();
        chk("rst_mid", 32'(dut_v), 0);
        rst = 1'b0;
        tick();
        chk("rst_rewarm", 32'(busy), 1);
        wait_fs(n);
        chk("rst_lat", n, EXP_LAT - 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
